// File: rtl/modinv_arbiter_pkg.sv
// ============================================================================
// modinv_arbiter_pkg : shared state encoding and constants for modinv_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package modinv_arbiter_pkg;

   localparam int W_DEF = 256;

   // secp256k1 field prime, handy as a realistic modulus in benches
   localparam logic [255:0] SECP256K1_P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/modinv_arbiter_rr_pick.sv
// ============================================================================
// modinv_arbiter_rr_pick : rotating priority encoder, first valid at/after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module modinv_arbiter_rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [PW-1:0]   idx_o
);

   logic [PW:0] k;
   logic        found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      k       = '0;
      for (int i = 0; i < NREQ; i++) begin
         // ptr_i + i never exceeds 2*NREQ-2, so a single subtract wraps it
         k = {1'b0, ptr_i} + (PW+1)'(i);
         if (k >= (PW+1)'(NREQ)) k = k - (PW+1)'(NREQ);
         if (!found && valid_i[k[PW-1:0]]) begin
            found               = 1'b1;
            grant_o[k[PW-1:0]]  = 1'b1;
            idx_o               = k[PW-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/modinv_arbiter.sv
// ============================================================================
// modinv_arbiter : round-robin sharing of one modinv core among NREQ requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module modinv_arbiter
   import modinv_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int W       = W_DEF,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_m,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   resp_valid,
   output logic              resp_err,
   output logic [W-1:0]      resp_c,
   output logic              mi_start,
   output logic [W-1:0]      mi_b,
   output logic [W-1:0]      mi_a,
   output logic [W-1:0]      mi_m,
   input  logic [W-1:0]      mi_c,
   input  logic              mi_ready
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_e         state_q, state_d;
   logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]  owner_q, owner_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   mi_b_q, mi_b_d;
   logic [W-1:0]   mi_a_q, mi_a_d;
   logic [W-1:0]   mi_m_q, mi_m_d;
   logic [W-1:0]   resp_c_q, resp_c_d;
   logic           resp_err_q, resp_err_d;

   logic [NREQ-1:0] pick_grant;
   logic [PW-1:0]   pick_idx;

   modinv_arbiter_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .valid_i (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         cnt_q      <= '0;
         mi_b_q     <= '0;
         mi_a_q     <= '0;
         mi_m_q     <= '0;
         resp_c_q   <= '0;
         resp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         mi_b_q     <= mi_b_d;
         mi_a_q     <= mi_a_d;
         mi_m_q     <= mi_m_d;
         resp_c_q   <= resp_c_d;
         resp_err_q <= resp_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      mi_b_d     = mi_b_q;
      mi_a_d     = mi_a_q;
      mi_m_d     = mi_m_q;
      resp_c_d   = resp_c_q;
      resp_err_d = resp_err_q;
      req_ready  = '0;
      resp_valid = '0;
      mi_start   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               req_ready = pick_grant;
               mi_b_d    = req_b[int'(pick_idx)*W +: W];
               mi_a_d    = req_a[int'(pick_idx)*W +: W];
               mi_m_d    = req_m[int'(pick_idx)*W +: W];
               owner_d   = pick_idx;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mi_start = 1'b1;
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            // core may still show ready from the previous job this cycle
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mi_ready) begin
               resp_c_d   = mi_c;
               resp_err_d = 1'b0;
               state_d    = ST_RESP;
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
               resp_c_d   = '0;
               resp_err_d = 1'b1;
               state_d    = ST_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RESP: begin
            resp_valid[owner_q] = 1'b1;
            rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mi_b     = mi_b_q;
   assign mi_a     = mi_a_q;
   assign mi_m     = mi_m_q;
   assign resp_c   = resp_c_q;
   assign resp_err = resp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_modinv_arbiter.sv
// ============================================================================
// tb_modinv_arbiter : randomized bench for modinv_arbiter with a modinv core model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_modinv_arbiter;
   import modinv_arbiter_pkg::*;

   localparam int NREQ    = 4;
   localparam int W       = 256;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*W-1:0] req_b = '0, req_a = '0, req_m = '0;
   logic [NREQ-1:0]   req_ready, resp_valid;
   logic              resp_err, mi_start, mi_ready;
   logic [W-1:0]      resp_c, mi_b, mi_a, mi_m, mi_c;

   always #5 clk = ~clk;

   modinv_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_b(req_b), .req_a(req_a), .req_m(req_m),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err), .resp_c(resp_c),
      .mi_start(mi_start), .mi_b(mi_b), .mi_a(mi_a), .mi_m(mi_m),
      .mi_c(mi_c), .mi_ready(mi_ready)
   );

   int n_tests = 0, n_fail = 0;

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] m);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      p = p % {{W{1'b0}}, m};
      return p[W-1:0];
   endfunction

   // b * a^-1 mod m for prime m, via Fermat: a^-1 = a^(m-2)
   function automatic logic [W-1:0] ref_div(input logic [W-1:0] b, input logic [W-1:0] a,
                                            input logic [W-1:0] m);
      logic [W-1:0] e, r, x;
      e = m - 2;
      r = 1;
      x = a % m;
      for (int i = 0; i < W; i++) begin
         if ((e >> i) == '0) break;
         if (e[i]) r = mulmod(r, x, m);
         x = mulmod(x, x, m);
      end
      return mulmod(b % m, r, m);
   endfunction

   function automatic logic [W-1:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Core model: ready drops on start, rises job_lat cycles later with the result
   int           job_lat = 4;
   bit           hang = 1'b0;
   int           ccnt;
   logic [W-1:0] cres;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mi_ready <= 1'b1;
         mi_c     <= '0;
         ccnt     <= 0;
         cres     <= '0;
      end else if (mi_start) begin
         mi_ready <= 1'b0;
         ccnt     <= job_lat;
         cres     <= ref_div(mi_b, mi_a, mi_m);
         mi_c     <= rnd256();
      end else if (!mi_ready && ccnt > 0) begin
         ccnt <= ccnt - 1;
         if (ccnt == 1 && !hang) begin
            mi_ready <= 1'b1;
            mi_c     <= cres;
         end
      end
   end

   // Reference model of the arbiter, in terms of jobs and cycles
   logic [NREQ-1:0] pend = '0;
   logic [W-1:0]    opb [NREQ];
   logic [W-1:0]    opa [NREQ];
   logic [W-1:0]    opm [NREQ];
   bit              busy = 1'b0;
   int              ptr = 0, owner = 0, cyc = 0, start_cyc = -1, resp_cyc = -1;
   int              force_lat = 0;
   logic [W-1:0]    job_b, job_a, job_m, exp_c;
   bit              exp_err;
   int              gq [$];
   int              obs_acc = -1, obs_resp = -1;

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [W-1:0] b, input logic [W-1:0] a,
                          input logic [W-1:0] m);
      opb[i] = b; opa[i] = a; opm[i] = m; pend[i] = 1'b1;
   endtask

   task automatic rand_req(input int i);
      logic [W-1:0] m, a, b;
      case ($urandom_range(0, 3))
         0:       m = 7;
         1:       m = 65521;
         2:       m = 2147483647;
         default: m = SECP256K1_P;
      endcase
      a = rnd256() % m;
      if (a == '0) a = 1;
      b = rnd256() % m;
      set_req(i, b, a, m);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_req_ready"},  req_ready, '0);
      check_val({tag, "_resp_valid"}, resp_valid, '0);
      check_val({tag, "_resp_err"},   resp_err, '0);
      check_val({tag, "_resp_c"},     resp_c, '0);
      check_val({tag, "_mi_start"},   mi_start, '0);
      check_val({tag, "_mi_b"},       mi_b, '0);
      check_val({tag, "_mi_a"},       mi_a, '0);
      check_val({tag, "_mi_m"},       mi_m, '0);
   endtask

   task automatic apply_reset();
      pend = '0;
      req_valid = '0;
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_zero("rst");
      rst_n = 1'b1;
      busy = 1'b0; ptr = 0; owner = 0; cyc = 0; start_cyc = -1; resp_cyc = -1;
   endtask

   // One clock cycle, entered and left just after a rising edge
   task automatic run_cycle();
      logic [NREQ-1:0] exp_rdy, exp_rv;
      int w;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = pend[i];
         req_b[i*W +: W] = opb[i];
         req_a[i*W +: W] = opa[i];
         req_m[i*W +: W] = opm[i];
      end
      #1;
      exp_rdy = '0; exp_rv = '0; w = -1;
      if (!busy) begin
         w = pick(pend, ptr);
         if (w >= 0) exp_rdy[w] = 1'b1;
      end
      if (busy && cyc == resp_cyc) exp_rv[owner] = 1'b1;
      check_val("req_ready", req_ready, exp_rdy);
      check_val("mi_start", mi_start, cyc == start_cyc);
      check_val("resp_valid", resp_valid, exp_rv);
      if (cyc == start_cyc) begin
         check_val("mi_b", mi_b, job_b);
         check_val("mi_a", mi_a, job_a);
         check_val("mi_m", mi_m, job_m);
      end
      if (exp_rv != '0) begin
         check_val("resp_c", resp_c, exp_c);
         check_val("resp_err", resp_err, exp_err);
      end
      for (int i = 0; i < NREQ; i++)
         if (req_ready[i]) begin gq.push_back(i); obs_acc = cyc; end
      if (resp_valid != '0) obs_resp = cyc;
      @(posedge clk);
      #1;
      cyc++;
      if (exp_rv != '0) begin
         busy = 1'b0;
         ptr = (owner + 1) % NREQ;
      end else if (w >= 0) begin
         busy = 1'b1;
         owner = w;
         pend[w] = 1'b0;
         job_b = opb[w]; job_a = opa[w]; job_m = opm[w];
         start_cyc = cyc;
         job_lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 12));
         if (hang) begin
            resp_cyc = cyc + 2 + TIMEOUT;
            exp_c = '0;
            exp_err = 1'b1;
         end else begin
            resp_cyc = cyc + 2 + job_lat;
            exp_c = ref_div(job_b, job_a, job_m);
            exp_err = 1'b0;
         end
      end
   endtask

   task automatic run_until_idle();
      for (int n = 0; n < 400 && (busy || pend != '0); n++) run_cycle();
      for (int n = 0; n < 2; n++) run_cycle();
   endtask

   task automatic check_order(input string tag, input int exp_q [$]);
      check_val({tag, "_count"}, gq.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < gq.size(); j++)
         check_val(tag, gq[j], exp_q[j]);
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin opb[i] = '0; opa[i] = '0; opm[i] = '0; end
      apply_reset();

      // small values on requester 2: 5 * 3^-1 mod 7 = 4
      gq.delete();
      set_req(2, 5, 3, 7);
      run_until_idle();
      check_val("small_c", resp_c, 4);
      check_order("small_grant", '{2});

      // all four valid from reset, then a re-request from 0
      apply_reset();
      gq.delete();
      force_lat = 10;
      for (int i = 0; i < NREQ; i++) rand_req(i);
      run_until_idle();
      rand_req(0);
      run_until_idle();
      check_order("rotate", '{0, 1, 2, 3, 0});

      // fairness: owner 1 finishing with 1 and 3 both waiting
      gq.delete();
      force_lat = 0;
      rand_req(1);
      for (int n = 0; n < 4 && !busy; n++) run_cycle();
      rand_req(1);
      rand_req(3);
      run_until_idle();
      check_order("fair", '{1, 3, 1});

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) rand_req(i);
            else if (pend[i] && $urandom_range(0, 31) == 0) pend[i] = 1'b0;
         end
         run_cycle();
      end
      run_until_idle();

      // reset while the arbiter waits on the core
      force_lat = 10;
      rand_req(0);
      for (int n = 0; n < 30 && !(busy && cyc == start_cyc + 3); n++) run_cycle();
      rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      apply_reset();
      for (int n = 0; n < 20; n++) run_cycle();
      rand_req(3);
      run_until_idle();

      // watchdog: core never answers
      gq.delete();
      hang = 1'b1;
      force_lat = 5;
      rand_req(2);
      run_until_idle();
      check_val("wd_latency", obs_resp - obs_acc, 19);
      hang = 1'b0;
      force_lat = 3;
      rand_req(1);
      run_until_idle();
      check_order("wd_next", '{2, 1});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
